pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 109 ++++++++++
 tb/tb_pipe_skid_reg.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline register (main + skid) with registered in_ready, flush and
// a saturating stall counter. Payloads leave in strict arrival order.
module pipe_skid_reg #(
    parameter int DATA_W         = 32,
    parameter int CNT_W          = 16,
    parameter int CLEAR_ON_FLUSH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Handshake: a transfer happens on a rising edge where valid && ready on that
    // side. in_ready/out_valid come from registered state only, so neither side
    // ever sees a combinational path from the other.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic              in_xfer;
    logic              out_xfer;

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_q;      // state encoding doubles as held-entry count
    assign stall_cnt = stall_cnt_q;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Squash wins over any same-cycle input or output transfer.
            state_d = EMPTY;
            if (CLEAR_ON_FLUSH != 0) begin
                main_d = '0;
                skid_d = '0;
            end
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_d = in_data;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end else if (in_xfer) begin
                        skid_d  = in_data;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // Counts every edge with data waiting downstream; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: reset, streaming, backpressure, flush,
// mid-stream reset and stall-counter saturation, with an in-order scoreboard.
module tb_pipe_skid_reg;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        flush;
    logic        out_ready;

    logic        in_ready,  in_ready_nc,  in_ready_sat;
    logic        out_valid, out_valid_nc, out_valid_sat;
    logic [31:0] out_data,  out_data_nc,  out_data_sat;
    logic [1:0]  occupancy, occupancy_nc, occupancy_sat;
    logic [15:0] stall_cnt, stall_cnt_nc;
    logic [3:0]  stall_cnt_sat;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    pipe_skid_reg dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .occupancy(occupancy),
        .stall_cnt(stall_cnt)
    );

    pipe_skid_reg #(.CLEAR_ON_FLUSH(0)) dut_nc (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_nc),
        .in_data(in_data), .flush(flush), .out_valid(out_valid_nc),
        .out_ready(out_ready), .out_data(out_data_nc), .occupancy(occupancy_nc),
        .stall_cnt(stall_cnt_nc)
    );

    pipe_skid_reg #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_sat),
        .in_data(in_data), .flush(flush), .out_valid(out_valid_sat),
        .out_ready(out_ready), .out_data(out_data_sat), .occupancy(occupancy_sat),
        .stall_cnt(stall_cnt_sat)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs, score the transfers that happen at the next
    // edge, then advance to 1 time unit after that edge.
    task automatic cycle(input logic iv, input logic [31:0] id, input logic ordy, input logic fl);
        logic [31:0] front;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #2;
        if (out_valid && out_ready && !fl) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 64'(exp_q.size()), 64'd1);
            end else begin
                front = exp_q.pop_front();
                check("sb_order", 64'(out_data), 64'(front));
            end
        end
        if (fl) exp_q.delete();
        else if (in_valid && in_ready) exp_q.push_back(in_data);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        flush = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        rst = 1'b1;

        // Streaming 0x1..0x8 with out_ready held high
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 32'(i), 1'b1, 1'b0);
            check("stream_data", 64'(out_data), 64'(i));
            check("stream_occ", 64'(occupancy), 64'd1);
        end
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        check("stream_drained", 64'(out_valid), 64'd0);

        // Backpressure: 0xA, 0xB held, extra push refused while FULL
        cycle(1'b1, 32'hA, 1'b0, 1'b0);
        cycle(1'b1, 32'hB, 1'b0, 1'b0);
        check("bp_occ_full", 64'(occupancy), 64'd2);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_data_a", 64'(out_data), 64'hA);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 32'hEE, 1'b0, 1'b0);
        check("bp_data_stable", 64'(out_data), 64'hA);
        check("bp_occ_hold", 64'(occupancy), 64'd2);
        check("bp_stall_cnt", 64'(stall_cnt), 64'd3);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        check("bp_data_b", 64'(out_data), 64'hB);
        check("bp_occ_one", 64'(occupancy), 64'd1);
        check("bp_in_ready_back", 64'(in_ready), 64'd1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        check("bp_drained", 64'(out_valid), 64'd0);
        check("bp_stall_final", 64'(stall_cnt), 64'd3);

        // Flush while FULL with a same-cycle push of 0xC
        cycle(1'b1, 32'hA, 1'b0, 1'b0);
        cycle(1'b1, 32'hB, 1'b0, 1'b0);
        check("fl_occ_full", 64'(occupancy), 64'd2);
        cycle(1'b1, 32'hC, 1'b0, 1'b1);
        check("fl_occ", 64'(occupancy), 64'd0);
        check("fl_out_valid", 64'(out_valid), 64'd0);
        check("fl_out_data", 64'(out_data), 64'd0);
        check("fl_stall_kept", 64'(stall_cnt), 64'd5);
        check("fl_nc_out_valid", 64'(out_valid_nc), 64'd0);
        check("fl_nc_data_held", 64'(out_data_nc), 64'hA);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        check("fl_no_c", 64'(out_valid), 64'd0);
        cycle(1'b1, 32'h5, 1'b1, 1'b0);
        check("fl_resume", 64'(out_data), 64'h5);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        check("fl_resume_drain", 64'(out_valid), 64'd0);

        // Reset mid-stream while FULL
        cycle(1'b1, 32'h11, 1'b0, 1'b0);
        cycle(1'b1, 32'h22, 1'b0, 1'b0);
        check("mr_occ_full", 64'(occupancy), 64'd2);
        check("mr_stall_pre", 64'(stall_cnt), 64'd6);
        #2 rst = 1'b0;
        #1;
        check("mr_out_valid", 64'(out_valid), 64'd0);
        check("mr_out_data", 64'(out_data), 64'd0);
        check("mr_occ", 64'(occupancy), 64'd0);
        check("mr_in_ready", 64'(in_ready), 64'd1);
        check("mr_stall_cnt", 64'(stall_cnt), 64'd0);
        in_valid = 1'b1;
        in_data = 32'h33;
        @(posedge clk);
        #1;
        check("mr_push_lost", 64'(out_valid), 64'd0);
        rst = 1'b1;
        exp_q.delete();
        cycle(1'b1, 32'h44, 1'b1, 1'b0);
        check("mr_first_accept", 64'(out_data), 64'h44);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        check("mr_drain", 64'(out_valid), 64'd0);

        // Stall counter saturation (CNT_W = 4 instance)
        rst = 1'b0;
        #2 rst = 1'b1;
        exp_q.delete();
        cycle(1'b1, 32'h77, 1'b0, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b0);
            if (k == 14) check("sat_14", 64'(stall_cnt_sat), 64'd14);
            if (k == 15) check("sat_15", 64'(stall_cnt_sat), 64'd15);
        end
        check("sat_hold", 64'(stall_cnt_sat), 64'd15);
        check("sat_wide_20", 64'(stall_cnt), 64'd20);
        check("sat_data", 64'(out_data), 64'h77);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        check("sat_drain", 64'(out_valid), 64'd0);
        check("sb_empty_end", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
